// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game flow controller: state encodings,
// parameter defaults and the spawn-interval helper.
package game_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int unsigned LIVES_INIT_DEF    = 3;
    localparam int unsigned SPAWN_PERIOD_DEF  = 60;
    localparam int unsigned SPAWN_MIN_DEF     = 15;
    localparam int unsigned DYING_FRAMES_DEF  = 90;
    localparam int unsigned INVULN_FRAMES_DEF = 120;

    localparam logic [13:0] SCORE_MAX = 14'h3FFF;

    // Spawns speed up by one frame per 16 points, never dropping below the floor;
    // the subtraction is clamped so a huge score cannot wrap to a long interval.
    function automatic logic [15:0] spawn_interval(input logic [13:0] score,
                                                   input logic [15:0] period,
                                                   input logic [15:0] floor_iv);
        logic [15:0] dec;
        logic [15:0] raw;
        dec = {6'd0, score[13:4]};
        raw = (dec >= period) ? 16'd0 : (period - dec);
        return (raw < floor_iv) ? floor_iv : raw;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_edge_det.sv
// Rising-edge detector: a held level produces a single one-cycle pulse.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: IDLE/PLAY/DYING/OVER sequencing, lives, score and enemy
// spawn pacing. Define HISCORE_EN to add the hiscore_o register and port.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int unsigned LIVES_INIT    = LIVES_INIT_DEF,
    parameter int unsigned SPAWN_PERIOD  = SPAWN_PERIOD_DEF,
    parameter int unsigned SPAWN_MIN     = SPAWN_MIN_DEF,
    parameter int unsigned DYING_FRAMES  = DYING_FRAMES_DEF,
    parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick_i,
    input  logic        start_i,
    input  logic        crash_me_enemy_i,
    input  logic        crash_enemy_bullet_i,
    output logic [1:0]  state_o,
    output logic        play_en_o,
    output logic        invuln_o,
    output logic [1:0]  lives_o,
    output logic [13:0] score_o,
`ifdef HISCORE_EN
    output logic [13:0] hiscore_o,
`endif
    output logic        spawn_req_o
);

    state_t      state;
    logic        start_rise;
    logic        me_rise;
    logic        bullet_rise;
    logic [15:0] spawn_cnt;
    logic [15:0] dying_cnt;
    logic [15:0] invuln_cnt;
    logic [15:0] interval;

    edge_det u_start_det  (.clk(clk), .rst(rst), .d(start_i),              .rise(start_rise));
    edge_det u_me_det     (.clk(clk), .rst(rst), .d(crash_me_enemy_i),     .rise(me_rise));
    edge_det u_bullet_det (.clk(clk), .rst(rst), .d(crash_enemy_bullet_i), .rise(bullet_rise));

    assign interval  = spawn_interval(score_o, 16'(SPAWN_PERIOD), 16'(SPAWN_MIN));
    assign state_o   = state;
    assign play_en_o = (state == ST_PLAY);
    assign invuln_o  = (invuln_cnt != 16'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            lives_o     <= 2'd0;
            score_o     <= 14'd0;
            spawn_req_o <= 1'b0;
            spawn_cnt   <= 16'd0;
            dying_cnt   <= 16'd0;
            invuln_cnt  <= 16'd0;
`ifdef HISCORE_EN
            hiscore_o   <= 14'd0;
`endif
        end else begin
            spawn_req_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state      <= ST_PLAY;
                        lives_o    <= 2'(LIVES_INIT);
                        score_o    <= 14'd0;
                        spawn_cnt  <= 16'd0;
                        invuln_cnt <= 16'd0;
                    end
                end
                ST_PLAY: begin
                    if (bullet_rise && (score_o != SCORE_MAX)) begin
                        score_o <= score_o + 14'd1;
                    end
                    if (frame_tick_i) begin
                        if (invuln_cnt != 16'd0) begin
                            invuln_cnt <= invuln_cnt - 16'd1;
                        end
                        if (spawn_cnt >= (interval - 16'd1)) begin
                            spawn_req_o <= 1'b1;
                            spawn_cnt   <= 16'd0;
                        end else begin
                            spawn_cnt <= spawn_cnt + 16'd1;
                        end
                    end
                    // The invulnerability test uses the pre-tick value on purpose.
                    if (me_rise && (invuln_cnt == 16'd0)) begin
                        lives_o   <= lives_o - 2'd1;
                        dying_cnt <= 16'd0;
                        state     <= ST_DYING;
                    end
                end
                ST_DYING: begin
                    if (frame_tick_i) begin
                        if (dying_cnt == 16'(DYING_FRAMES - 1)) begin
                            if (lives_o == 2'd0) begin
                                state <= ST_OVER;
`ifdef HISCORE_EN
                                if (score_o > hiscore_o) begin
                                    hiscore_o <= score_o;
                                end
`endif
                            end else begin
                                state      <= ST_PLAY;
                                invuln_cnt <= 16'(INVULN_FRAMES);
                            end
                        end else begin
                            dying_cnt <= dying_cnt + 16'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (start_rise) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl against a frame-level reference model.
module tb_game_flow_ctrl;

    localparam int LIVES  = 3;
    localparam int PERIOD = 60;
    localparam int SMIN   = 15;
    localparam int DYING  = 90;
    localparam int INVULN = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick_i = 1'b0;
    logic        start_i = 1'b0;
    logic        crash_me_enemy_i = 1'b0;
    logic        crash_enemy_bullet_i = 1'b0;
    logic [1:0]  state_o;
    logic        play_en_o;
    logic        invuln_o;
    logic [1:0]  lives_o;
    logic [13:0] score_o;
    logic        spawn_req_o;
`ifdef HISCORE_EN
    logic [13:0] hiscore_o;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_state, m_lives, m_score, m_ticks, m_dying_left, m_invuln, m_hiscore;
    bit m_spawn;
    bit p_start, p_me, p_bul;

    game_flow_ctrl #(
        .LIVES_INIT(LIVES), .SPAWN_PERIOD(PERIOD), .SPAWN_MIN(SMIN),
        .DYING_FRAMES(DYING), .INVULN_FRAMES(INVULN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick_i(frame_tick_i),
        .start_i(start_i),
        .crash_me_enemy_i(crash_me_enemy_i),
        .crash_enemy_bullet_i(crash_enemy_bullet_i),
        .state_o(state_o),
        .play_en_o(play_en_o),
        .invuln_o(invuln_o),
        .lives_o(lives_o),
        .score_o(score_o),
`ifdef HISCORE_EN
        .hiscore_o(hiscore_o),
`endif
        .spawn_req_o(spawn_req_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_score = 0; m_ticks = 0;
        m_dying_left = 0; m_invuln = 0; m_hiscore = 0; m_spawn = 1'b0;
        p_start = 1'b0; p_me = 1'b0; p_bul = 1'b0;
    endtask

    // One clock of game rules, written in terms of frames remaining / elapsed.
    task automatic model_update(input bit s, input bit m, input bit b, input bit t);
        bit es, em, eb;
        int iv, inv0;
        es = s && !p_start; em = m && !p_me; eb = b && !p_bul;
        p_start = s; p_me = m; p_bul = b;
        m_spawn = 1'b0;
        inv0 = m_invuln;
        iv = PERIOD - (m_score / 16);
        if (iv < SMIN) iv = SMIN;
        case (m_state)
            0: if (es) begin
                m_state = 1; m_lives = LIVES; m_score = 0; m_ticks = 0; m_invuln = 0;
            end
            1: begin
                if (t) begin
                    if (m_invuln > 0) m_invuln--;
                    m_ticks++;
                    if (m_ticks >= iv) begin m_spawn = 1'b1; m_ticks = 0; end
                end
                if (eb && m_score < 16383) m_score++;
                if (em && inv0 == 0) begin
                    m_lives--; m_state = 2; m_dying_left = DYING;
                end
            end
            2: if (t) begin
                m_dying_left--;
                if (m_dying_left == 0) begin
                    if (m_lives == 0) begin
                        m_state = 3;
                        if (m_score > m_hiscore) m_hiscore = m_score;
                    end else begin
                        m_state = 1; m_invuln = INVULN;
                    end
                end
            end
            3: if (es) m_state = 0;
            default: ;
        endcase
    endtask

    task automatic step(input bit s, input bit m, input bit b, input bit t);
        start_i = s; crash_me_enemy_i = m; crash_enemy_bullet_i = b; frame_tick_i = t;
        @(posedge clk);
        model_update(s, m, b, t);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({state_o, lives_o, score_o, invuln_o, spawn_req_o, play_en_o} !== 21'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got st=%0d lives=%0d score=%0d inv=%0d spawn=%0d play=%0d want all 0",
                     state_o, lives_o, score_o, invuln_o, spawn_req_o, play_en_o);
        end
        #3 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_start();
        step(1, 0, 0, 0);
        total++;
        if (state_o !== 2'd1 || lives_o !== 2'd3 || score_o !== 14'd0 || play_en_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL start_play: got st=%0d lives=%0d score=%0d play=%0d want 1 3 0 1",
                     state_o, lives_o, score_o, play_en_o);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_score_play();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
            repeat ($urandom_range(0, 3)) step(0, 0, 0, ($urandom_range(0, 2) == 0));
        end
        total++;
        if (score_o !== 14'd20) begin
            bad++;
            $display("[TB] FAIL score_play: got %0d want 20", score_o);
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        total++;
        if (state_o !== 2'd1) begin
            bad++;
            $display("[TB] FAIL start_in_play_ignored: got st=%0d want 1", state_o);
        end
    endtask

    task automatic test_death_invuln();
        repeat (10) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        total++;
        if (lives_o !== 2'd2 || state_o !== 2'd2 || play_en_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL held_crash: got lives=%0d st=%0d play=%0d want 2 2 0", lives_o, state_o, play_en_o);
        end
        repeat (89) begin step(0, 0, 0, 1); step(0, 0, 0, 0); end
        total++;
        if (state_o !== 2'd2) begin
            bad++;
            $display("[TB] FAIL dying_89: got st=%0d want 2", state_o);
        end
        step(0, 0, 0, 1);
        total++;
        if (state_o !== 2'd1 || invuln_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL respawn: got st=%0d inv=%0d want 1 1", state_o, invuln_o);
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        total++;
        if (lives_o !== 2'd2 || state_o !== 2'd1) begin
            bad++;
            $display("[TB] FAIL invuln_crash_ignored: got lives=%0d st=%0d want 2 1", lives_o, state_o);
        end
        repeat (119) begin step(0, 0, 0, 1); step(0, 0, 0, 0); end
        total++;
        if (invuln_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL invuln_119: got %0d want 1", invuln_o);
        end
        step(0, 0, 0, 1);
        total++;
        if (invuln_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL invuln_120: got %0d want 0", invuln_o);
        end
    endtask

    task automatic test_game_over();
        for (int d = 0; d < 2; d++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
            total++;
            if (lives_o !== 2'(1 - d) || state_o !== 2'd2) begin
                bad++;
                $display("[TB] FAIL death_%0d: got lives=%0d st=%0d want %0d 2", d, lives_o, state_o, 1 - d);
            end
            repeat (DYING) begin step(0, 0, 0, 1); step(0, 0, 0, 0); end
            if (d == 0) repeat (INVULN) step(0, 0, 0, 1);
        end
        total++;
        if (state_o !== 2'd3 || play_en_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL game_over: got st=%0d play=%0d want 3 0", state_o, play_en_o);
        end
`ifdef HISCORE_EN
        total++;
        if (hiscore_o !== 14'd20) begin
            bad++;
            $display("[TB] FAIL hiscore: got %0d want 20", hiscore_o);
        end
`endif
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        total++;
        if (state_o !== 2'd0) begin
            bad++;
            $display("[TB] FAIL over_to_idle: got st=%0d want 0", state_o);
        end
    endtask

    task automatic test_score_idle();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, ($urandom_range(0, 1) == 0));
            step(0, 0, 0, 0);
        end
        total++;
        if (score_o !== 14'd20 || state_o !== 2'd0) begin
            bad++;
            $display("[TB] FAIL score_idle: got score=%0d st=%0d want 20 0", score_o, state_o);
        end
    endtask

    task automatic test_spawn();
        int last, pulses;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        last = 0; pulses = 0;
        for (int j = 1; j <= 180; j++) begin
            step(0, 0, 0, 1);
            total++;
            if (spawn_req_o !== m_spawn) begin
                bad++;
                $display("[TB] FAIL spawn60_tick%0d: got %0d want %0d", j, spawn_req_o, m_spawn);
            end
            if (spawn_req_o === 1'b1) begin
                pulses++;
                total++;
                if (j - last !== PERIOD) begin
                    bad++;
                    $display("[TB] FAIL spawn60_gap: got %0d want %0d", j - last, PERIOD);
                end
                last = j;
            end
            step(0, 0, 0, 0);
        end
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("[TB] FAIL spawn60_count: got %0d want 3", pulses);
        end
        repeat (800) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        total++;
        if (score_o !== 14'd800) begin
            bad++;
            $display("[TB] FAIL score_800: got %0d want 800", score_o);
        end
        last = 0; pulses = 0;
        for (int j = 1; j <= 45; j++) begin
            step(0, 0, 0, 1);
            if (spawn_req_o === 1'b1) begin
                pulses++;
                total++;
                if (j - last !== SMIN) begin
                    bad++;
                    $display("[TB] FAIL spawn15_gap: got %0d want %0d", j - last, SMIN);
                end
                last = j;
            end
            step(0, 0, 0, 0);
        end
        total++;
        if (pulses !== 3) begin
            bad++;
            $display("[TB] FAIL spawn15_count: got %0d want 3", pulses);
        end
    endtask

    task automatic test_saturation();
        int pulses;
        repeat (15600) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        total++;
        if (score_o !== 14'd16383) begin
            bad++;
            $display("[TB] FAIL score_saturate: got %0d want 16383", score_o);
        end
        pulses = 0;
        for (int j = 1; j <= 30; j++) begin
            step(0, 0, 0, 1);
            if (spawn_req_o === 1'b1) pulses++;
            step(0, 0, 0, 0);
        end
        total++;
        if (pulses !== 2) begin
            bad++;
            $display("[TB] FAIL spawn_at_max_score: got %0d pulses want 2", pulses);
        end
    endtask

    task automatic test_reset_dying();
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        #3 rst = 1'b0;
        #1;
        total++;
        if ({state_o, lives_o, score_o, invuln_o, spawn_req_o, play_en_o} !== 21'd0) begin
            bad++;
            $display("[TB] FAIL async_reset_dying: got st=%0d lives=%0d score=%0d inv=%0d spawn=%0d play=%0d want all 0",
                     state_o, lives_o, score_o, invuln_o, spawn_req_o, play_en_o);
        end
`ifdef HISCORE_EN
        total++;
        if (hiscore_o !== 14'd0) begin
            bad++;
            $display("[TB] FAIL hiscore_reset: got %0d want 0", hiscore_o);
        end
`endif
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        total++;
        if (score_o !== 14'd1 || lives_o !== 2'd2 || state_o !== 2'd2) begin
            bad++;
            $display("[TB] FAIL same_cycle_crash: got score=%0d lives=%0d st=%0d want 1 2 2", score_o, lives_o, state_o);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [20:0] exp_v;
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            exp_v = {2'(m_state), 2'(m_lives), 14'(m_score), (m_invuln > 0), m_spawn, (m_state == 1)};
            total++;
            if ({state_o, lives_o, score_o, invuln_o, spawn_req_o, play_en_o} !== exp_v) begin
                bad++;
                $display("[TB] FAIL random_c%0d: got %h want %h", c,
                         {state_o, lives_o, score_o, invuln_o, spawn_req_o, play_en_o}, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_score_play();
        test_death_invuln();
        test_game_over();
        test_score_idle();
        test_spawn();
        test_saturation();
        test_reset_dying();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
